// File: rtl/ising_l1_rd_arbiter_pkg.sv
// Shared types and constants for the L1 direct-port read arbiter.
//   arb_mode_e               : arbitration policy encoding (matches rr_mode_i)
//   IcL1DirectMaxOutstanding : default in-flight read depth
//   idx_width()              : index width helper, never narrower than 1 bit
package ising_l1_rd_arbiter_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int unsigned IcL1DirectMaxOutstanding = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ising_l1_rd_arbiter_tag_fifo.sv
// One-hot issuer-tag FIFO for in-order response routing.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/push_data_i : enqueue a tag (ignored when full)
//   pop_i         : dequeue the head tag (ignored when empty)
//   head_o        : current head tag
//   full_o/empty_o: occupancy flags
module ising_l1_rd_arbiter_tag_fifo
    import ising_l1_rd_arbiter_pkg::*;
#(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_cnt;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (r_cnt == CntW'(Depth));
    assign empty_o = (r_cnt == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign head_o  = r_mem[r_rptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Tag storage; contents are only observed through a valid head.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= push_data_i;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o));

endmodule

// File: rtl/ising_l1_rd_arbiter.sv
// Arbitrates NumClients read requesters onto one memory direct port and
// routes each in-order response back to its issuer via a one-hot tag FIFO.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   client_en_i       : per-client enable mask
//   rr_mode_i         : 0 fixed priority (lowest index), 1 round-robin
//   cl_req_valid_i/cl_req_ready_o/cl_addr_i : client request channel
//   cl_rsp_valid_o/cl_rsp_data_o            : one-hot response, shared data
//   mem_q_valid_o/mem_q_ready_i/mem_q_addr_o: memory request channel
//   mem_p_valid_i/mem_p_data_i              : in-order memory responses
//   idle_o            : nothing pending or in flight
//   err_o             : sticky orphan-response flag
module ising_l1_rd_arbiter
    import ising_l1_rd_arbiter_pkg::*;
#(
    parameter int unsigned NumClients     = 2,
    parameter int unsigned AddrWidth      = 10,
    parameter int unsigned DataWidth      = 256,
    parameter int unsigned MaxOutstanding = IcL1DirectMaxOutstanding,
    parameter int unsigned RspReg         = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumClients-1:0]           client_en_i,
    input  logic                            rr_mode_i,
    input  logic [NumClients-1:0]           cl_req_valid_i,
    output logic [NumClients-1:0]           cl_req_ready_o,
    input  logic [NumClients*AddrWidth-1:0] cl_addr_i,
    output logic [NumClients-1:0]           cl_rsp_valid_o,
    output logic [DataWidth-1:0]            cl_rsp_data_o,
    output logic                            mem_q_valid_o,
    input  logic                            mem_q_ready_i,
    output logic [AddrWidth-1:0]            mem_q_addr_o,
    input  logic                            mem_p_valid_i,
    input  logic [DataWidth-1:0]            mem_p_data_i,
    output logic                            idle_o,
    output logic                            err_o
);

    localparam int unsigned IdxW = idx_width(NumClients);

    arb_mode_e             w_mode;
    logic [NumClients-1:0] w_elig;
    logic [AddrWidth-1:0]  w_addr [NumClients];
    logic [IdxW-1:0]       w_base;
    logic [IdxW-1:0]       w_cand;
    logic [IdxW-1:0]       w_arb_idx;
    logic                  w_arb_found;
    logic                  w_lock_hold;
    logic [IdxW-1:0]       w_gnt_idx;
    logic                  w_gnt_any;
    logic [NumClients-1:0] w_gnt_oh;
    logic                  w_hs;
    logic                  w_full;
    logic                  w_empty;
    logic [NumClients-1:0] w_head;
    logic                  w_pop;
    logic [NumClients-1:0] w_rsp_vec;
    logic                  w_rsp_busy;

    logic                  r_lock;
    logic [IdxW-1:0]       r_lock_idx;
    logic [IdxW-1:0]       r_rr_ptr;
    logic                  r_err;

    assign w_mode = arb_mode_e'(rr_mode_i);
    assign w_elig = cl_req_valid_i & client_en_i;

    for (genvar i = 0; i < NumClients; i++) begin : g_addr
        assign w_addr[i] = cl_addr_i[i*AddrWidth +: AddrWidth];
    end

    // Search for the first eligible client starting at the base index.
    always_comb begin
        w_arb_idx   = '0;
        w_arb_found = 1'b0;
        w_cand      = '0;
        w_base      = (w_mode == ARB_RR) ? r_rr_ptr : '0;
        for (int unsigned k = 0; k < NumClients; k++) begin
            w_cand = IdxW'((32'(w_base) + k) % NumClients);
            if (!w_arb_found && w_elig[w_cand]) begin
                w_arb_idx   = w_cand;
                w_arb_found = 1'b1;
            end
        end
    end

    // A stalled grant stays on its client while that client keeps valid,
    // regardless of enables or newly arriving higher-priority requests.
    assign w_lock_hold = r_lock & cl_req_valid_i[r_lock_idx];
    assign w_gnt_idx   = w_lock_hold ? r_lock_idx : w_arb_idx;
    assign w_gnt_any   = w_lock_hold | w_arb_found;

    always_comb begin
        w_gnt_oh            = '0;
        w_gnt_oh[w_gnt_idx] = 1'b1;
    end

    // Issue is gated only by FIFO occupancy, never by this cycle's pop.
    assign mem_q_valid_o  = w_gnt_any & ~w_full;
    assign mem_q_addr_o   = w_addr[w_gnt_idx];
    assign w_hs           = mem_q_valid_o & mem_q_ready_i;
    assign cl_req_ready_o = w_hs ? w_gnt_oh : '0;

    ising_l1_rd_arbiter_tag_fifo #(
        .Width (NumClients),
        .Depth (MaxOutstanding)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_hs),
        .push_data_i (w_gnt_oh),
        .pop_i       (mem_p_valid_i),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // Lock, round-robin pointer and sticky orphan flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_lock     <= mem_q_valid_o & ~mem_q_ready_i;
            r_lock_idx <= w_gnt_idx;
            if (w_hs && (w_mode == ARB_RR)) begin
                r_rr_ptr <= (w_gnt_idx == IdxW'(NumClients - 1)) ? '0
                                                                  : w_gnt_idx + IdxW'(1);
            end
            if (mem_p_valid_i && w_empty) r_err <= 1'b1;
        end
    end

    // Responses with no tag outstanding are dropped.
    assign w_pop     = mem_p_valid_i & ~w_empty;
    assign w_rsp_vec = w_pop ? w_head : '0;

    if (RspReg != 0) begin : g_rsp_reg
        logic [NumClients-1:0] r_rsp_valid;
        logic [DataWidth-1:0]  r_rsp_data;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_rsp_valid <= '0;
                r_rsp_data  <= '0;
            end else begin
                r_rsp_valid <= w_rsp_vec;
                if (w_pop) r_rsp_data <= mem_p_data_i;
            end
        end

        assign cl_rsp_valid_o = r_rsp_valid;
        assign cl_rsp_data_o  = r_rsp_data;
        assign w_rsp_busy     = |r_rsp_valid;
    end else begin : g_rsp_comb
        assign cl_rsp_valid_o = w_rsp_vec;
        assign cl_rsp_data_o  = mem_p_data_i;
        assign w_rsp_busy     = 1'b0;
    end

    assign idle_o = w_empty & ~(|w_elig) & ~w_rsp_busy;
    assign err_o  = r_err;

    a_rsp_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(cl_rsp_valid_o));

    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_q_valid_o && !mem_q_ready_i) |=> $stable(mem_q_addr_o));

    // A locked client dropping valid before its handshake is a protocol error.
    a_lock_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_q_valid_o && !mem_q_ready_i) |=> mem_q_valid_o);

endmodule
